// File: rtl/vga_pkg.sv
// VGA timing constants, stream record and draw_rect defaults shared by the pixel pipeline.
// 800x600 visible area inside a 1056x628 total raster.
package vga_pkg;
  localparam int HOR_PIXELS  = 800;
  localparam int VER_PIXELS  = 600;
  localparam int HOR_TOT_PIX = 1056;
  localparam int VER_TOT_PIX = 628;
  localparam int RGB_W       = 12;
  localparam int CNT_W       = 11;

  localparam int               RECT_W_DEF     = 48;
  localparam int               RECT_H_DEF     = 64;
  localparam logic [RGB_W-1:0] RECT_COLOR_DEF = 12'hF80;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hblnk;
    logic             vblnk;
    logic             hsync;
    logic             vsync;
    logic [RGB_W-1:0] rgb;
  } vga_t;

  typedef enum logic {
    SHADOW_EMPTY = 1'b0,
    SHADOW_FULL  = 1'b1
  } shadow_state_e;
endpackage

// File: rtl/vga_if.sv
// VGA timing + colour stream passed between draw stages; no flow control, one pixel per clk.
interface vga_if;
  import vga_pkg::*;

  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hblnk;
  logic             vblnk;
  logic             hsync;
  logic             vsync;
  logic [RGB_W-1:0] rgb;

  modport in  (input  hcount, vcount, hblnk, vblnk, hsync, vsync, rgb);
  modport out (output hcount, vcount, hblnk, vblnk, hsync, vsync, rgb);
endinterface

// File: rtl/vga_delay.sv
// Generic register pipeline for a vga_if stream: DEPTH clk latency on every field, no backpressure.
module vga_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  vga_if.in    in,
  vga_if.out   out
);
  vga_t r_pipe [DEPTH];
  vga_t w_in;

  assign w_in = {in.hcount, in.vcount, in.hblnk, in.vblnk, in.hsync, in.vsync, in.rgb};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_in;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign out.hcount = r_pipe[DEPTH-1].hcount;
  assign out.vcount = r_pipe[DEPTH-1].vcount;
  assign out.hblnk  = r_pipe[DEPTH-1].hblnk;
  assign out.vblnk  = r_pipe[DEPTH-1].vblnk;
  assign out.hsync  = r_pipe[DEPTH-1].hsync;
  assign out.vsync  = r_pipe[DEPTH-1].vsync;
  assign out.rgb    = r_pipe[DEPTH-1].rgb;
endmodule

// File: rtl/draw_rect.sv
// Overlays a fixed-size solid rectangle on the vga stream; 2 clk latency on every field.
// Position arrives on valid/ready into a one-deep shadow, applied only at the frame boundary.
module draw_rect
  import vga_pkg::*;
#(
  parameter int               RECT_W     = RECT_W_DEF,
  parameter int               RECT_H     = RECT_H_DEF,
  parameter logic [RGB_W-1:0] RECT_COLOR = RECT_COLOR_DEF,
  parameter logic [CNT_W-1:0] XPOS_INIT  = '0,
  parameter logic [CNT_W-1:0] YPOS_INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  vga_if.in                in,
  vga_if.out               out,
  input  logic [CNT_W-1:0] xpos,
  input  logic [CNT_W-1:0] ypos,
  input  logic             pos_valid,
  output logic             pos_ready
);
  localparam int XW = CNT_W + 1;

  vga_if w_s1 ();
  vga_if w_s2 ();

  shadow_state_e    r_state, w_state_nxt;
  logic [CNT_W-1:0] r_ax, r_ay, r_sx, r_sy;
  logic             r_hit, w_hit, w_fe, w_take, w_apply;
  logic [XW-1:0]    w_x_end, w_y_end;

  // Ends are one bit wider so a rectangle near the right/bottom edge clips rather than wraps.
  assign w_x_end = {1'b0, r_ax} + XW'(RECT_W);
  assign w_y_end = {1'b0, r_ay} + XW'(RECT_H);
  assign w_hit   = (in.hcount >= r_ax) && ({1'b0, in.hcount} < w_x_end) &&
                   (in.vcount >= r_ay) && ({1'b0, in.vcount} < w_y_end) &&
                   !in.hblnk && !in.vblnk;
  assign w_fe    = (in.hcount == CNT_W'(HOR_TOT_PIX - 1)) &&
                   (in.vcount == CNT_W'(VER_TOT_PIX - 1));

  vga_delay #(.DEPTH(1)) u_stage1 (.clk(clk), .rst(rst), .in(in), .out(w_s1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_hit <= 1'b0;
    else     r_hit <= w_hit;
  end

  assign w_s2.hcount = w_s1.hcount;
  assign w_s2.vcount = w_s1.vcount;
  assign w_s2.hblnk  = w_s1.hblnk;
  assign w_s2.vblnk  = w_s1.vblnk;
  assign w_s2.hsync  = w_s1.hsync;
  assign w_s2.vsync  = w_s1.vsync;
  assign w_s2.rgb    = r_hit ? RECT_COLOR : w_s1.rgb;

  vga_delay #(.DEPTH(1)) u_stage2 (.clk(clk), .rst(rst), .in(w_s2), .out(out));

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      SHADOW_EMPTY: if (pos_valid) begin
        w_take      = 1'b1;
        w_state_nxt = SHADOW_FULL;
      end
      SHADOW_FULL: if (w_fe) begin
        w_apply     = 1'b1;
        w_state_nxt = SHADOW_EMPTY;
      end
      default: w_state_nxt = SHADOW_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SHADOW_EMPTY;
      r_ax    <= XPOS_INIT;
      r_ay    <= YPOS_INIT;
      r_sx    <= '0;
      r_sy    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_sx <= xpos;
        r_sy <= ypos;
      end
      if (w_apply) begin
        r_ax <= r_sx;
        r_ay <= r_sy;
      end
    end
  end

  assign pos_ready = (r_state == SHADOW_EMPTY);
endmodule

// File: tb/tb_draw_rect.sv
// Randomized bench for draw_rect: sparse raster pixels plus frame-end events, checked against
// a frame-level model of active/shadow position and a 2-clk output delay.
`timescale 1ns/1ps
module tb_draw_rect;
  import vga_pkg::*;

  localparam int          XI  = 100;
  localparam int          YI  = 50;
  localparam int          RW  = 48;
  localparam int          RH  = 64;
  localparam logic [11:0] COL = 12'hF80;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] xpos, ypos;
  logic        pos_valid, pos_ready;

  vga_if vin ();
  vga_if vout ();

  always #5 clk = ~clk;

  draw_rect #(
    .RECT_W(RW), .RECT_H(RH), .RECT_COLOR(COL),
    .XPOS_INIT(11'(XI)), .YPOS_INIT(11'(YI))
  ) dut (
    .clk(clk), .rst(rst), .in(vin), .out(vout),
    .xpos(xpos), .ypos(ypos), .pos_valid(pos_valid), .pos_ready(pos_ready)
  );

  int   errors = 0;
  int   checks = 0;
  int   m_ax, m_ay, m_sx, m_sy;
  bit   m_full;
  bit   accepted;
  bit   rand_bg;
  vga_t m_prev, exp_vga, obs_vga;
  logic exp_rdy, obs_rdy;

  task automatic model_reset();
    m_ax   = XI;
    m_ay   = YI;
    m_sx   = 0;
    m_sy   = 0;
    m_full = 1'b0;
    m_prev = '0;
  endtask

  // Drive one pixel, advance the model across the clock edge, sample outputs at the falling edge.
  task automatic step(input int h, input int v);
    vga_t cur;
    bit   hit, fe;
    cur.hcount = 11'(h);
    cur.vcount = 11'(v);
    cur.hblnk  = (h >= HOR_PIXELS);
    cur.vblnk  = (v >= VER_PIXELS);
    cur.hsync  = (h >= 840 && h < 968);
    cur.vsync  = (v >= 601 && v < 605);
    cur.rgb    = rand_bg ? 12'($urandom) : 12'h000;
    vin.hcount = cur.hcount;
    vin.vcount = cur.vcount;
    vin.hblnk  = cur.hblnk;
    vin.vblnk  = cur.vblnk;
    vin.hsync  = cur.hsync;
    vin.vsync  = cur.vsync;
    vin.rgb    = cur.rgb;
    hit = !cur.hblnk && !cur.vblnk && h >= m_ax && h < m_ax + RW && v >= m_ay && v < m_ay + RH;
    fe  = (h == HOR_TOT_PIX - 1) && (v == VER_TOT_PIX - 1);
    @(posedge clk);
    accepted = 1'b0;
    if (rst) begin
      model_reset();
      exp_vga = '0;
    end else begin
      exp_vga = m_prev;
      m_prev  = cur;
      if (hit) m_prev.rgb = COL;
      accepted = pos_valid && !m_full;
      if (fe && m_full) begin
        m_ax   = m_sx;
        m_ay   = m_sy;
        m_full = 1'b0;
      end else if (accepted) begin
        m_sx   = int'(xpos);
        m_sy   = int'(ypos);
        m_full = 1'b1;
      end
    end
    exp_rdy = !m_full;
    @(negedge clk);
    obs_vga = {vout.hcount, vout.vcount, vout.hblnk, vout.vblnk, vout.hsync, vout.vsync, vout.rgb};
    obs_rdy = pos_ready;
  endtask

  // Pixels around the edges of the rectangle at (cx,cy), inside it, and anywhere in the raster.
  task automatic scan_frame(input string tag, input int cx, input int cy);
    int hs[$];
    int vs[$];
    int dxs[4];
    int dys[4];
    dxs = '{-1, 0, RW - 1, RW};
    dys = '{-1, 0, RH - 1, RH};
    foreach (dxs[i]) foreach (dys[j]) begin
      if (cx + dxs[i] >= 0 && cx + dxs[i] < HOR_TOT_PIX - 1 &&
          cy + dys[j] >= 0 && cy + dys[j] < VER_TOT_PIX - 1) begin
        hs.push_back(cx + dxs[i]);
        vs.push_back(cy + dys[j]);
      end
    end
    for (int k = 0; k < 8; k++) begin
      hs.push_back((cx + int'($urandom_range(0, RW - 1))) % (HOR_TOT_PIX - 1));
      vs.push_back((cy + int'($urandom_range(0, RH - 1))) % (VER_TOT_PIX - 1));
    end
    for (int k = 0; k < 16; k++) begin
      hs.push_back(int'($urandom_range(0, HOR_TOT_PIX - 2)));
      vs.push_back(int'($urandom_range(0, VER_TOT_PIX - 2)));
    end
    foreach (hs[k]) begin
      step(hs[k], vs[k]);
      checks++;
      if (obs_vga !== exp_vga || obs_rdy !== exp_rdy)
        begin
          errors++;
          $display("FAIL %s px(%0d,%0d): out=%h rdy=%b, want out=%h rdy=%b",
                   tag, hs[k], vs[k], obs_vga, obs_rdy, exp_vga, exp_rdy);
        end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pos_valid = 1'b0;
    xpos = '0;
    ypos = '0;
    vin.hcount = '0; vin.vcount = '0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
    vin.hsync = 1'b0; vin.vsync = 1'b0; vin.rgb = '0;
    model_reset();
    repeat (3) @(negedge clk);
    obs_vga = {vout.hcount, vout.vcount, vout.hblnk, vout.vblnk, vout.hsync, vout.vsync, vout.rgb};
    checks++;
    if (obs_vga !== vga_t'('0) || pos_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: out=%h rdy=%b, want out=0 rdy=1", obs_vga, pos_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_init_rect();
    rand_bg = 1'b0;
    scan_frame("init", XI, YI);
    step(XI + RW - 1, YI + RH - 1);
    step(XI + RW, YI + RH - 1);
    checks++;
    if (obs_vga.rgb !== COL || obs_vga.hcount !== 11'(XI + RW - 1)) begin
      errors++;
      $display("FAIL init_corner: hc=%0d rgb=%h, want hc=%0d rgb=%h", obs_vga.hcount, obs_vga.rgb, XI + RW - 1, COL);
    end
    step(0, 0);
    checks++;
    if (obs_vga.rgb !== 12'h000) begin
      errors++;
      $display("FAIL init_outside: rgb=%h, want 000", obs_vga.rgb);
    end
    step(HOR_TOT_PIX - 1, VER_TOT_PIX - 1);
  endtask

  task automatic test_move();
    rand_bg = 1'b1;
    step(20, 300);
    xpos = 11'd400; ypos = 11'd200; pos_valid = 1'b1;
    step(30, 300);
    pos_valid = 1'b0;
    checks++;
    if (obs_rdy !== 1'b0) begin
      errors++;
      $display("FAIL move_rdy_drop: rdy=%b, want 0", obs_rdy);
    end
    scan_frame("move_old", XI, YI);
    step(HOR_TOT_PIX - 1, VER_TOT_PIX - 1);
    checks++;
    if (obs_rdy !== 1'b1) begin
      errors++;
      $display("FAIL move_rdy_rise: rdy=%b, want 1", obs_rdy);
    end
    scan_frame("move_new", 400, 200);
    step(400, 200);
    step(0, 0);
    checks++;
    if (obs_vga.rgb !== COL) begin
      errors++;
      $display("FAIL move_new_px: rgb=%h, want %h", obs_vga.rgb, COL);
    end
    step(HOR_TOT_PIX - 1, VER_TOT_PIX - 1);
  endtask

  task automatic test_stall();
    xpos = 11'd300; ypos = 11'd100; pos_valid = 1'b1;
    for (int n = 0; n < 8 && !accepted; n++) step(10 + n, 20);
    checks++;
    if (obs_rdy !== 1'b0) begin
      errors++;
      $display("FAIL stall_first: rdy=%b, want 0", obs_rdy);
    end
    xpos = 11'd600; ypos = 11'd400;
    for (int n = 0; n < 10; n++) begin
      step(int'($urandom_range(0, 1000)), int'($urandom_range(0, 620)));
      checks++;
      if (obs_rdy !== 1'b0 || obs_vga !== exp_vga) begin
        errors++;
        $display("FAIL stall_hold: out=%h rdy=%b, want out=%h rdy=0", obs_vga, obs_rdy, exp_vga);
      end
    end
    step(HOR_TOT_PIX - 1, VER_TOT_PIX - 1);
    step(5, 5);
    pos_valid = 1'b0;
    checks++;
    if (obs_rdy !== 1'b0 || m_sx != 600) begin
      errors++;
      $display("FAIL stall_accept: rdy=%b, want 0 after second transfer", obs_rdy);
    end
    scan_frame("stall_first", 300, 100);
    step(HOR_TOT_PIX - 1, VER_TOT_PIX - 1);
    scan_frame("stall_second", 600, 400);
    step(HOR_TOT_PIX - 1, VER_TOT_PIX - 1);
  endtask

  task automatic test_clip();
    int hv[5][2];
    logic [11:0] want[5];
    xpos = 11'd780; ypos = 11'd580; pos_valid = 1'b1;
    step(1, 1);
    pos_valid = 1'b0;
    step(HOR_TOT_PIX - 1, VER_TOT_PIX - 1);
    scan_frame("clip", 780, 580);
    rand_bg = 1'b0;
    hv   = '{'{799, 599}, '{800, 599}, '{799, 600}, '{5, 5}, '{780, 0}};
    want = '{COL, 12'h000, 12'h000, 12'h000, 12'h000};
    step(hv[0][0], hv[0][1]);
    for (int k = 0; k < 5; k++) begin
      step(k < 4 ? hv[k+1][0] : 0, k < 4 ? hv[k+1][1] : 0);
      checks++;
      if (obs_vga.rgb !== want[k] || obs_vga.hcount !== 11'(hv[k][0])) begin
        errors++;
        $display("FAIL clip_px(%0d,%0d): rgb=%h, want %h", hv[k][0], hv[k][1], obs_vga.rgb, want[k]);
      end
    end
    rand_bg = 1'b1;
  endtask

  task automatic test_fe_same_cycle();
    xpos = 11'd200; ypos = 11'd300; pos_valid = 1'b1;
    step(HOR_TOT_PIX - 1, VER_TOT_PIX - 1);
    pos_valid = 1'b0;
    checks++;
    if (obs_rdy !== 1'b0) begin
      errors++;
      $display("FAIL fe_same_accept: rdy=%b, want 0", obs_rdy);
    end
    scan_frame("fe_same_old", 780, 580);
    step(HOR_TOT_PIX - 1, VER_TOT_PIX - 1);
    scan_frame("fe_same_new", 200, 300);
  endtask

  task automatic test_reset_mid();
    xpos = 11'd50; ypos = 11'd60; pos_valid = 1'b1;
    step(499, 300);
    pos_valid = 1'b0;
    step(500, 300);
    #2;
    rst = 1'b1;
    #1;
    obs_vga = {vout.hcount, vout.vcount, vout.hblnk, vout.vblnk, vout.hsync, vout.vsync, vout.rgb};
    checks++;
    if (obs_vga !== vga_t'('0) || pos_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_async: out=%h rdy=%b, want out=0 rdy=1", obs_vga, pos_ready);
    end
    model_reset();
    for (int n = 0; n < 3; n++) begin
      step(501 + n, 300);
      checks++;
      if (obs_vga !== vga_t'('0) || obs_rdy !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_hold: out=%h rdy=%b, want out=0 rdy=1", obs_vga, obs_rdy);
      end
    end
    rst = 1'b0;
    scan_frame("reset_realign", XI, YI);
    step(HOR_TOT_PIX - 1, VER_TOT_PIX - 1);
    scan_frame("reset_init_pos", XI, YI);
  endtask

  initial begin
    rand_bg = 1'b0;
    test_reset();
    test_init_rect();
    test_move();
    test_stall();
    test_clip();
    test_fe_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
